// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    // Half must sit on an even byte, word on a 4-byte boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables/data placement and load extract + extend.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);
    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b0000;
        wword_o = 32'h0;
        rdata_o = 32'h0;
        shifted = rword_i >> {addr_lo_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
                rdata_o = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder of the CPU load/store port: one request at a time,
// fixed-latency byte/half/word access into a local word-organised RAM.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       rdata_o,
    output logic              err_o
);
    localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_L  = (ADDR_W-2)'(DEPTH_WORDS);
    localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              accept, enter_resp, bad;
    logic              sel_we, sel_uns;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata, rword, wword, ext;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;

    assign accept     = (state_q == IDLE) && req_i;
    assign enter_resp = (LATENCY == 1) ? accept : ((state_q == WAIT) && (cnt_q == 4'd1));

    // In IDLE the access (if LATENCY==1) happens on the accepting edge, so use live inputs.
    assign sel_we    = (state_q == IDLE) ? we_i       : we_q;
    assign sel_uns   = (state_q == IDLE) ? unsigned_i : uns_q;
    assign sel_size  = (state_q == IDLE) ? size_i     : size_q;
    assign sel_addr  = (state_q == IDLE) ? addr_i     : addr_q;
    assign sel_wdata = (state_q == IDLE) ? wdata_i    : wdata_q;

    assign bad   = (sel_size == 2'b11) || misaligned(sel_size, sel_addr[1:0])
                || (sel_addr[ADDR_W-1:2] >= DEPTH_L);
    assign idx   = sel_addr[2 +: IDX_W];
    assign rword = mem_q[idx];

    dmem_lane_align u_align (
        .size_i    (sel_size),
        .unsigned_i(sel_uns),
        .addr_lo_i (sel_addr[1:0]),
        .wdata_i   (sel_wdata),
        .rword_i   (rword),
        .be_o      (be),
        .wword_o   (wword),
        .rdata_o   (ext)
    );

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == RESP);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_i) begin
                cnt_d   = CNT_INIT;
                state_d = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                rdata_q <= (sel_we || bad) ? 32'h0 : ext;
                err_q   <= bad;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= we_i;
            uns_q   <= unsigned_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    // A store only touches RAM on the edge entering RESP; a reset before that drops it.
    always_ff @(posedge clk_i) begin
        if (enter_resp && sel_we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (LATENCY 1, 2, 3) against a byte-array reference model.
module tb_dmem_responder;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [3];
    logic        ready [3];
    logic        we    [3];
    logic [1:0]  size  [3];
    logic        uns   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        valid [3];
    logic        rresp [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int checks = 0;
    int errors = 0;

    // Reference memory: one byte array per build, covering byte addresses 0..255.
    logic [7:0] mm [3][256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(g + 1)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst_n),
            .req_i       (req[g]),
            .ready_o     (ready[g]),
            .we_i        (we[g]),
            .size_i      (size[g]),
            .unsigned_i  (uns[g]),
            .addr_i      (addr[g]),
            .wdata_i     (wdata[g]),
            .valid_o     (valid[g]),
            .resp_ready_i(rresp[g]),
            .rdata_o     (rdata[g]),
            .err_o       (err[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected response from the access rules: n-byte access, aligned to n, below 4*DEPTH.
    task automatic model(input int k, input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit e, output logic [31:0] rd);
        int     n;
        longint v;
        n  = 1 << sz;
        e  = (sz == 2'b11) || ((a % n) != 0) || (a >= 4 * DEPTH);
        rd = 32'h0;
        if (e) return;
        if (w) begin
            for (int i = 0; i < n; i++) mm[k][a + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(mm[k][a + i]) << (8 * i));
            if (!u && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
            rd = v[31:0];
        end
    endtask

    // Called at a negedge with build k idle; returns at a negedge with k idle again.
    task automatic txn(input int k, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       output logic [31:0] o_rd, output logic o_err);
        bit          e_exp;
        logic [31:0] r_exp, held;
        int          n;
        model(k, w, sz, u, a, wd, e_exp, r_exp);
        chk("ready_idle", 32'(ready[k]), 32'd1);
        req[k] = 1'b1; we[k] = w; size[k] = sz; uns[k] = u; addr[k] = a; wdata[k] = wd;
        @(posedge clk);
        @(negedge clk);
        req[k] = 1'b0;
        n = 1;
        while (!valid[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(k + 1));
        chk("rdata", rdata[k], r_exp);
        chk("err", 32'(err[k]), 32'(e_exp));
        o_rd  = rdata[k];
        o_err = err[k];
        held  = rdata[k];
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(valid[k]), 32'd1);
            chk("hold_rdata", rdata[k], held);
            chk("hold_ready", 32'(ready[k]), 32'd0);
        end
        rresp[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rresp[k] = 1'b0;
        chk("resp_done", 32'(valid[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, a, wd, q_rd[$];
        logic        e;
        logic [1:0]  sz;
        int          cyc, last, got, issued;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 0; we[k] = 0; size[k] = 0; uns[k] = 0;
            addr[k] = 0; wdata[k] = 0; rresp[k] = 0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", 32'(ready[k]), 32'd1);
            chk("rst_valid", 32'(valid[k]), 32'd0);
            chk("rst_rdata", rdata[k], 32'h0);
            chk("rst_err", 32'(err[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during WAIT of a store (LATENCY=3) drops the store.
        txn(2, 1, 2'b10, 0, 32'h10, 32'h11111111, 0, rd, e);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b10; addr[2] = 32'h10; wdata[2] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        chk("wait_ready", 32'(ready[2]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready[2]), 32'd1);
        chk("midrst_valid", 32'(valid[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(2, 0, 2'b10, 0, 32'h10, 32'h0, 0, rd, e);
        chk("aborted_store", rd, 32'h11111111);

        // Fill the modelled region of builds 0 and 1 with random words.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++)
                txn(k, 1, 2'b10, 0, 32'(4 * i), $urandom, 0, rd, e);

        txn(1, 1, 2'b10, 0, 32'h20, 32'h12345678, 0, rd, e);
        txn(1, 0, 2'b00, 0, 32'h21, 32'h0, 0, rd, e);
        chk("t2_byte", rd, 32'h00000056);
        txn(1, 0, 2'b01, 0, 32'h22, 32'h0, 0, rd, e);
        chk("t2_half", rd, 32'h00001234);

        txn(1, 1, 2'b00, 0, 32'h23, 32'h00000080, 0, rd, e);
        txn(1, 0, 2'b00, 0, 32'h23, 32'h0, 0, rd, e);
        chk("t3_sbyte", rd, 32'hFFFFFF80);
        txn(1, 0, 2'b00, 1, 32'h23, 32'h0, 0, rd, e);
        chk("t3_ubyte", rd, 32'h00000080);
        txn(1, 0, 2'b10, 0, 32'h20, 32'h0, 0, rd, e);
        chk("t3_word", rd, 32'h80345678);

        txn(1, 0, 2'b10, 0, 32'h22, 32'h0, 0, rd, e);
        chk("t4_mis_err", 32'(e), 32'd1);
        chk("t4_mis_rd", rd, 32'h0);
        txn(1, 1, 2'b10, 0, 32'(4 * DEPTH), 32'hA5A5A5A5, 0, rd, e);
        chk("t4_oor_err", 32'(e), 32'd1);
        txn(1, 0, 2'b10, 0, 32'h0, 32'h0, 0, rd, e);
        txn(1, 0, 2'b11, 0, 32'h24, 32'h0, 0, rd, e);
        chk("t4_sz3_err", 32'(e), 32'd1);

        // Stall in RESP, then an immediate follow-on request.
        txn(1, 0, 2'b10, 0, 32'h20, 32'h0, 5, rd, e);
        txn(1, 0, 2'b01, 1, 32'h20, 32'h0, 0, rd, e);
        chk("t5_follow", rd, 32'h00005678);

        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) sz = 2'b11;
            a = 32'($urandom_range(0, 252));
            if ($urandom_range(0, 9) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
            txn(1, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2), rd, e);
        end

        // LATENCY=1: back-to-back loads with resp_ready tied high.
        rresp[0] = 1'b1;
        cyc = 0; last = 0; got = 0; issued = 0;
        while (got < 8 && cyc < 100) begin
            if (valid[0]) begin
                chk("b2b_rdata", rdata[0], q_rd.pop_front());
                if (got > 0) chk("b2b_spacing", 32'(cyc - last), 32'd2);
                last = cyc;
                got++;
            end
            if (ready[0]) begin
                if (issued < 8) begin
                    sz = 2'($urandom_range(0, 2));
                    a  = 32'($urandom_range(0, 63) * 4) + ((sz == 2'b00) ? 32'($urandom_range(0, 3)) :
                                                          (sz == 2'b01) ? 32'(2 * $urandom_range(0, 1)) : 32'h0);
                    req[0] = 1'b1; we[0] = 1'b0; size[0] = sz; uns[0] = 1'($urandom); addr[0] = a;
                    model(0, 0, sz, uns[0], a, 32'h0, e, wd);
                    q_rd.push_back(wd);
                    issued++;
                end else begin
                    req[0] = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        req[0] = 1'b0;
        rresp[0] = 1'b0;
        chk("b2b_count", 32'(got), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
